exponent_bit_streamer: RTL and testbench

- Producer end of the exponent-bit / consumed-pulse handshake used by the Montgomery accumulator.
- Accepts a BITS_IN_N-bit exponent as a stream of REGISTER_SIZE-bit blocks, least-significant block first.
- Presents the exponent one bit at a time, LSB first, and advances one bit per consumed pulse.
- Two-bank ping-pong storage, so the next exponent can load while the current one streams.

---
 rtl/exponent_bit_streamer.sv | 97 +++++++++
 tb/tb_exponent_bit_streamer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/exponent_bit_streamer.sv
// Two-bank ping-pong exponent store: loads REGISTER_SIZE-bit blocks LSB-block first
// and presents the exponent one bit at a time, advancing on each consumed pulse.
module exponent_bit_streamer #(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned BITS_IN_N     = 2048
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] block_in,
  output logic                     ready_out,
  input  logic                     consumed_in,
  output logic                     n_bit_out,
  output logic                     bit_valid_out,
  output logic                     last_bit_out,
  output logic                     done_out
);

  localparam int unsigned BLOCKS = BITS_IN_N / REGISTER_SIZE;
  localparam int unsigned WORD_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int unsigned BIT_W  = (REGISTER_SIZE > 1) ? $clog2(REGISTER_SIZE) : 1;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCKS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(REGISTER_SIZE - 1);

  logic [REGISTER_SIZE-1:0] r_bank [2][BLOCKS];
  logic [1:0]               r_full;
  logic                     r_wr_sel;
  logic                     r_rd_sel;
  logic [WORD_W-1:0]        r_wr_idx;
  logic [WORD_W-1:0]        r_rd_word;
  logic [BIT_W-1:0]         r_rd_bit;

  logic                     w_accept;
  logic                     w_consume;
  logic                     w_last_pos;
  logic [REGISTER_SIZE-1:0] w_rd_block;

  // Handshake and bit presentation, all decoded from registered state
  always_comb begin
    ready_out     = rst_in && !r_full[r_wr_sel];
    bit_valid_out = rst_in && r_full[r_rd_sel];
    w_rd_block    = r_bank[r_rd_sel][r_rd_word];
    w_last_pos    = (r_rd_word == LAST_WORD) && (r_rd_bit == LAST_BIT);
    n_bit_out     = bit_valid_out && w_rd_block[r_rd_bit];
    last_bit_out  = bit_valid_out && w_last_pos;
    w_accept      = valid_in && ready_out;
    w_consume     = consumed_in && bit_valid_out;
  end

  // Bank storage has no reset; the full flags alone decide what is live
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_bank[r_wr_sel][r_wr_idx] <= block_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_full    <= 2'b00;
      r_wr_sel  <= 1'b0;
      r_rd_sel  <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_word <= '0;
      r_rd_bit  <= '0;
      done_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;

      if (w_accept) begin
        if (r_wr_idx == LAST_WORD) begin
          r_full[r_wr_sel] <= 1'b1;
          r_wr_sel         <= ~r_wr_sel;
          r_wr_idx         <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + WORD_W'(1);
        end
      end

      // A fill and a drain can never target the same bank, so both flag updates are safe
      if (w_consume) begin
        if (w_last_pos) begin
          r_full[r_rd_sel] <= 1'b0;
          r_rd_sel         <= ~r_rd_sel;
          r_rd_word        <= '0;
          r_rd_bit         <= '0;
          done_out         <= 1'b1;
        end else if (r_rd_bit == LAST_BIT) begin
          r_rd_bit  <= '0;
          r_rd_word <= r_rd_word + WORD_W'(1);
        end else begin
          r_rd_bit <= r_rd_bit + BIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_exponent_bit_streamer.sv
// Scoreboard bench: stimulus queues each loaded exponent; a negedge monitor tracks
// bank occupancy and bit position and checks every output every cycle.
module tb_exponent_bit_streamer;

  localparam int unsigned RS     = 32;
  localparam int unsigned NB     = 64;
  localparam int unsigned BLOCKS = NB / RS;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          valid_in;
  logic [RS-1:0] block_in;
  logic          ready_out;
  logic          consumed_in;
  logic          n_bit_out;
  logic          bit_valid_out;
  logic          last_bit_out;
  logic          done_out;

  int n_vec = 0;
  int n_err = 0;

  logic [NB-1:0] sb_q[$];

  exponent_bit_streamer #(.REGISTER_SIZE(RS), .BITS_IN_N(NB)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .block_in     (block_in),
    .ready_out    (ready_out),
    .consumed_in  (consumed_in),
    .n_bit_out    (n_bit_out),
    .bit_valid_out(bit_valid_out),
    .last_bit_out (last_bit_out),
    .done_out     (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference model: stored exponents form a FIFO of at most two entries
  int n_complete = 0;
  int part_cnt   = 0;
  int bit_pos    = 0;
  bit exp_done   = 1'b0;

  initial begin
    logic [NB-1:0] cur;
    bit e_ready, e_bv, e_bit, new_done;
    @(posedge clk_in);
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        chk("rst_ready", 64'(ready_out), 64'd0);
        chk("rst_bit_valid", 64'(bit_valid_out), 64'd0);
        chk("rst_last", 64'(last_bit_out), 64'd0);
        chk("rst_n_bit", 64'(n_bit_out), 64'd0);
        chk("rst_done", 64'(done_out), 64'(exp_done));
        n_complete = 0;
        part_cnt   = 0;
        bit_pos    = 0;
        exp_done   = 1'b0;
        sb_q.delete();
      end else begin
        e_ready = (n_complete < 2);
        e_bv    = (n_complete > 0);
        cur     = '0;
        if (e_bv) begin
          if (sb_q.size() == 0) timeout("scoreboard_underflow");
          else cur = sb_q[0];
        end
        e_bit = e_bv ? cur[bit_pos] : 1'b0;
        chk("ready", 64'(ready_out), 64'(e_ready));
        chk("bit_valid", 64'(bit_valid_out), 64'(e_bv));
        chk($sformatf("n_bit[%0d]", bit_pos), 64'(n_bit_out), 64'(e_bit));
        chk("last_bit", 64'(last_bit_out), 64'(e_bv && bit_pos == NB - 1));
        chk("done", 64'(done_out), 64'(exp_done));
        new_done = 1'b0;
        if (consumed_in && e_bv) begin
          if (bit_pos == NB - 1) begin
            n_complete--;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            bit_pos  = 0;
            new_done = 1'b1;
          end else begin
            bit_pos++;
          end
        end
        if (valid_in && e_ready) begin
          part_cnt++;
          if (part_cnt == BLOCKS) begin
            part_cnt = 0;
            n_complete++;
          end
        end
        exp_done = new_done;
      end
    end
  end

  task automatic load(input logic [NB-1:0] v);
    sb_q.push_back(v);
    for (int b = 0; b < BLOCKS; b++) begin
      int k = 0;
      valid_in = 1'b1;
      block_in = v[b*RS +: RS];
      @(negedge clk_in);
      while (!ready_out && k < 3000) begin
        @(negedge clk_in);
        k++;
      end
      if (k >= 3000) timeout("load_ready");
      @(posedge clk_in);
      #1;
    end
    valid_in = 1'b0;
  endtask

  // gap 0: held high; gap > 0: one pulse per gap cycles; gap < 0: random
  task automatic consume(input int n, input int gap);
    int got = 0;
    int cyc = 0;
    int ph  = 0;
    while (got < n && cyc < 5000) begin
      if (gap == 0) consumed_in = 1'b1;
      else if (gap > 0) consumed_in = (ph == 0);
      else consumed_in = 1'($urandom_range(0, 1));
      @(negedge clk_in);
      if (consumed_in && bit_valid_out) got++;
      @(posedge clk_in);
      #1;
      cyc++;
      if (gap > 0) ph = (ph + 1) % gap;
    end
    consumed_in = 1'b0;
    if (got < n) timeout("consume_bits");
  endtask

  function automatic logic [NB-1:0] rand_exp();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst_in      = 1'b0;
    valid_in    = 1'b0;
    consumed_in = 1'b0;
    block_in    = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;

    // Bit order: 1,0,1 then zeros, bit 63 set
    load(64'h8000_0000_0000_0005);
    consume(64, 0);

    // Consume pulses with nothing loaded are ignored
    consumed_in = 1'b1;
    repeat (8) @(posedge clk_in);
    #1 consumed_in = 1'b0;
    load(rand_exp());
    consume(64, 7);

    // Ping-pong: second exponent loads while the first streams
    load(rand_exp());
    fork
      load(rand_exp());
      consume(64, 0);
    join
    consume(64, 7);

    // Backpressure: third load held while both banks are full
    load(rand_exp());
    load(rand_exp());
    fork
      load(rand_exp());
      begin
        repeat (10) @(posedge clk_in);
        #1;
        consume(64, 0);
      end
    join
    consume(128, -1);

    // Random exponents under random consume pattern
    fork
      begin
        for (int i = 0; i < 4; i++) load(rand_exp());
      end
      consume(256, -1);
    join

    // Reset mid-stream, then reload
    load(rand_exp());
    consume(20, 0);
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    load(64'h0000_0000_FFFF_FFFF);
    consume(64, 0);

    repeat (4) @(posedge clk_in);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
